// File: rtl/lcd_panel_responder_if.sv
// HD44780-style character LCD bus between the watch controller and the panel responder.
interface lcd_panel_responder_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA_IN;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;

    modport master (output LCD_E, LCD_RS, LCD_RW, LCD_DATA_IN,
                    input  LCD_DATA_OUT, LCD_DATA_OE);
    modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_DATA_IN,
                    output LCD_DATA_OUT, LCD_DATA_OE);
endinterface

// File: rtl/lcd_panel_responder.sv
// 16x2 character LCD responder: oversamples E, decodes on its falling edge,
// holds DDRAM and cursor/display state, and models the busy flag.
module lcd_panel_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1640
) (
    input  logic                   CLK_1M,
    input  logic                   RESET,
    lcd_panel_responder_if.slave   lcd,
    input  logic [4:0]             PEEK_ADDR,
    output logic [7:0]             PEEK_CHAR,
    output logic                   DISP_ON,
    output logic [6:0]             CURSOR_ADDR,
    output logic                   BUSY,
    output logic                   CMD_ERR
);
    localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;
    typedef struct packed {
        logic id, s, d, c, b, dl, n, f;
    } mode_t;
    localparam mode_t MODE_RST = '{id: 1'b1, default: 1'b0};

    state_t        state, state_nxt;
    logic          e_s1, e_s2, e_d;
    logic          cap_rs, cap_rw;
    logic [7:0]    cap_data;
    logic [7:0]    ddram [32];
    logic [6:0]    ac, ac_nxt;
    mode_t         mode, mode_nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    fill;
    logic [7:0]    data_out;
    logic          strobe, is_bfr, is_clr, bad, wr_en, accept, err_nxt;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            case (a)
                7'h0F:   return 7'h40;
                7'h4F:   return 7'h00;
                default: return a + 7'd1;
            endcase
        end
        case (a)
            7'h40:   return 7'h0F;
            7'h00:   return 7'h4F;
            default: return a - 7'd1;
        endcase
    endfunction

    function automatic logic [4:0] ac_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    function automatic logic in_map(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    assign BUSY             = (state != IDLE);
    assign CURSOR_ADDR      = ac;
    assign DISP_ON          = mode.d;
    assign PEEK_CHAR        = ddram[PEEK_ADDR];
    assign lcd.LCD_DATA_OUT = data_out;
    assign lcd.LCD_DATA_OE  = e_s2 & cap_rw;

    // Decode uses only the values captured while E was still seen high.
    always_comb begin
        strobe   = e_d & ~e_s2;
        is_bfr   = ~cap_rs & cap_rw;
        is_clr   = 1'b0;
        bad      = 1'b0;
        wr_en    = 1'b0;
        ac_nxt   = ac;
        mode_nxt = mode;
        if (cap_rs) begin
            wr_en  = ~cap_rw;
            ac_nxt = ac_step(ac, mode.id);
        end else if (!cap_rw) begin
            casez (cap_data)
                8'b1???????: begin
                    if (in_map(cap_data[6:0])) ac_nxt = cap_data[6:0];
                    else bad = 1'b1;
                end
                8'b01??????: bad = 1'b1;
                8'b001?????: {mode_nxt.dl, mode_nxt.n, mode_nxt.f} = cap_data[4:2];
                8'b0001????: if (!cap_data[3]) ac_nxt = ac_step(ac, cap_data[2]);
                8'b00001???: {mode_nxt.d, mode_nxt.c, mode_nxt.b} = cap_data[2:0];
                8'b000001??: {mode_nxt.id, mode_nxt.s} = cap_data[1:0];
                8'b0000001?: ac_nxt = 7'h00;
                8'b00000001: begin
                    is_clr      = 1'b1;
                    ac_nxt      = 7'h00;
                    mode_nxt.id = 1'b1;
                end
                default: ;
            endcase
        end
        accept  = strobe & ~is_bfr & ~BUSY & ~bad;
        err_nxt = strobe & ~is_bfr & (BUSY | bad);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (accept) state_nxt = is_clr ? CLEAR : EXEC;
            EXEC, CLEAR: if (cnt == '0) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_1M or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK_1M or posedge RESET) begin
        if (RESET) begin
            e_s1     <= 1'b0;
            e_s2     <= 1'b0;
            e_d      <= 1'b0;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
            for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
            ac       <= 7'h00;
            mode     <= MODE_RST;
            cnt      <= '0;
            fill     <= '0;
            data_out <= 8'h00;
            CMD_ERR  <= 1'b0;
        end else begin
            e_s1 <= lcd.LCD_E;
            e_s2 <= e_s1;
            e_d  <= e_s2;
            if (e_s2) begin
                cap_rs   <= lcd.LCD_RS;
                cap_rw   <= lcd.LCD_RW;
                cap_data <= lcd.LCD_DATA_IN;
                if (lcd.LCD_RW)
                    data_out <= lcd.LCD_RS ? ddram[ac_idx(ac)] : {BUSY, ac};
            end
            CMD_ERR <= err_nxt;
            if (cnt != '0) cnt <= cnt - CW'(1);
            // Clear fill runs in the first 32 cycles of the CLEAR busy window.
            if (state == CLEAR && !fill[5]) begin
                ddram[fill[4:0]] <= 8'h20;
                fill             <= fill + 6'd1;
            end
            if (accept) begin
                ac   <= ac_nxt;
                mode <= mode_nxt;
                if (wr_en) ddram[ac_idx(ac)] <= cap_data;
                if (is_clr) begin
                    cnt  <= CW'(CLEAR_CYCLES - 1);
                    fill <= '0;
                end else begin
                    cnt  <= CW'(BUSY_CYCLES - 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_panel_responder.sv
// Bench for lcd_panel_responder: directed vector table, busy/clear/reset corner
// sequences, then random bus traffic against a linear-cursor character model.
module tb_lcd_panel_responder;
    localparam int BC = 12;
    localparam int CC = 48;

    logic       CLK_1M = 1'b0;
    logic       RESET;
    logic [4:0] PEEK_ADDR;
    logic [7:0] PEEK_CHAR;
    logic       DISP_ON;
    logic [6:0] CURSOR_ADDR;
    logic       BUSY;
    logic       CMD_ERR;

    lcd_panel_responder_if lcd();

    lcd_panel_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
        .CLK_1M(CLK_1M), .RESET(RESET), .lcd(lcd),
        .PEEK_ADDR(PEEK_ADDR), .PEEK_CHAR(PEEK_CHAR), .DISP_ON(DISP_ON),
        .CURSOR_ADDR(CURSOR_ADDR), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK_1M = ~CLK_1M;

    int nchk = 0, nerr = 0;
    int err_seen = 0, busy_run = 0, last_run = 0;

    always @(posedge CLK_1M) begin
        if (CMD_ERR) err_seen++;
        if (BUSY) busy_run++;
        else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge CLK_1M);
        lcd.LCD_RS = rs; lcd.LCD_RW = rw; lcd.LCD_DATA_IN = d; lcd.LCD_E = 1'b1;
        repeat (4) @(negedge CLK_1M);
        if (rw) chk("oe_during_read", {31'd0, lcd.LCD_DATA_OE}, 32'd1);
        lcd.LCD_E = 1'b0;
        repeat (5) @(negedge CLK_1M);
    endtask

    // Reference model: cursor kept as a linear position 0..31 over both lines.
    logic [7:0] m_mem [32];
    int         m_lin;
    bit         m_id, m_d;

    function automatic logic [6:0] m_ac();
        return (m_lin < 16) ? 7'(m_lin) : 7'(8'h40 + m_lin - 16);
    endfunction

    function automatic void m_step(input bit inc);
        m_lin = (m_lin + (inc ? 1 : 31)) % 32;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_lin = 0; m_id = 1; m_d = 0;
    endfunction

    function automatic void m_apply(input bit rs, input bit rw, input logic [7:0] d,
                                    output bit e, output logic [7:0] out);
        int a;
        e = 0; out = 8'h00;
        if (rs && !rw) begin m_mem[m_lin] = d; m_step(m_id); end
        else if (rs) begin out = m_mem[m_lin]; m_step(m_id); end
        else if (rw) out = {1'b0, m_ac()};
        else if (d >= 8'h80) begin
            a = int'(d) - 128;
            if (a < 16) m_lin = a;
            else if (a >= 64 && a < 80) m_lin = a - 48;
            else e = 1;
        end
        else if (d >= 8'h40) e = 1;
        else if (d >= 8'h20) ;
        else if (d >= 8'h10) begin if (!d[3]) m_step(d[2]); end
        else if (d >= 8'h08) m_d = d[2];
        else if (d >= 8'h04) m_id = d[1];
        else if (d >= 8'h02) m_lin = 0;
        else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_lin = 0; m_id = 1;
        end
    endfunction

    task automatic check_mem(input string nm);
        for (int i = 0; i < 32; i++) begin
            PEEK_ADDR = 5'(i);
            #1;
            chk($sformatf("%s[%0d]", nm, i), {24'd0, PEEK_CHAR}, {24'd0, m_mem[i]});
        end
    endtask

    task automatic peek_chk(input int idx, input logic [7:0] exp);
        PEEK_ADDR = 5'(idx);
        #1;
        chk($sformatf("peek_%0d", idx), {24'd0, PEEK_CHAR}, {24'd0, exp});
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] ac;
        logic       err;
        logic       disp;
    } vec_t;
    vec_t tbl [18];

    initial begin
        int e0, polls, r;
        bit exp_e;
        logic [7:0] exp_o, d;
        logic rs, rw;

        tbl[0]  = '{0, 8'h38, 7'h00, 0, 0};
        tbl[1]  = '{0, 8'h0C, 7'h00, 0, 1};
        tbl[2]  = '{0, 8'h06, 7'h00, 0, 1};
        tbl[3]  = '{1, 8'h41, 7'h01, 0, 1};
        tbl[4]  = '{1, 8'h42, 7'h02, 0, 1};
        tbl[5]  = '{0, 8'h8F, 7'h0F, 0, 1};
        tbl[6]  = '{1, 8'h31, 7'h40, 0, 1};
        tbl[7]  = '{1, 8'h32, 7'h41, 0, 1};
        tbl[8]  = '{0, 8'h80, 7'h00, 0, 1};
        tbl[9]  = '{0, 8'h04, 7'h00, 0, 1};
        tbl[10] = '{1, 8'h5A, 7'h4F, 0, 1};
        tbl[11] = '{0, 8'h95, 7'h4F, 1, 1};
        tbl[12] = '{0, 8'h40, 7'h4F, 1, 1};
        tbl[13] = '{0, 8'h85, 7'h05, 0, 1};
        tbl[14] = '{0, 8'h14, 7'h06, 0, 1};
        tbl[15] = '{0, 8'h10, 7'h05, 0, 1};
        tbl[16] = '{0, 8'h18, 7'h05, 0, 1};
        tbl[17] = '{0, 8'h08, 7'h05, 0, 0};

        RESET = 1'b1; PEEK_ADDR = '0;
        lcd.LCD_E = 1'b0; lcd.LCD_RS = 1'b0; lcd.LCD_RW = 1'b0; lcd.LCD_DATA_IN = 8'h00;
        repeat (3) @(negedge CLK_1M);
        RESET = 1'b0;
        repeat (2) @(negedge CLK_1M);
        m_reset();
        check_mem("rst_peek");
        chk("rst_ac",   {25'd0, CURSOR_ADDR}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_disp", {31'd0, DISP_ON}, 32'd0);
        chk("rst_oe",   {31'd0, lcd.LCD_DATA_OE}, 32'd0);
        chk("rst_out",  {24'd0, lcd.LCD_DATA_OUT}, 32'd0);
        chk("rst_err",  {31'd0, CMD_ERR}, 32'd0);

        foreach (tbl[i]) begin
            e0 = err_seen;
            bus_op(tbl[i].rs, 1'b0, tbl[i].d);
            repeat (BC + 2) @(negedge CLK_1M);
            chk($sformatf("tbl%0d_ac", i),   {25'd0, CURSOR_ADDR}, {25'd0, tbl[i].ac});
            chk($sformatf("tbl%0d_err", i),  err_seen - e0, {31'd0, tbl[i].err});
            chk($sformatf("tbl%0d_disp", i), {31'd0, DISP_ON}, {31'd0, tbl[i].disp});
            if (i == 4) chk("exec_busy_len", last_run, BC);
        end
        peek_chk(0, 8'h5A); peek_chk(1, 8'h42); peek_chk(2, 8'h20);
        peek_chk(15, 8'h31); peek_chk(16, 8'h32);

        // Second write lands while the first is still executing.
        e0 = err_seen;
        bus_op(1'b1, 1'b0, 8'h55);
        bus_op(1'b1, 1'b0, 8'h66);
        repeat (BC + 2) @(negedge CLK_1M);
        chk("busy_rej_err", err_seen - e0, 32'd1);
        peek_chk(5, 8'h55); peek_chk(4, 8'h20);
        chk("busy_rej_ac", {25'd0, CURSOR_ADDR}, 32'h04);

        // Clear with busy-flag polling.
        e0 = err_seen;
        bus_op(1'b0, 1'b0, 8'h01);
        bus_op(1'b0, 1'b1, 8'h00);
        chk("clr_poll_first", {24'd0, lcd.LCD_DATA_OUT}, 32'h80);
        polls = 0;
        while (lcd.LCD_DATA_OUT[7] && polls < 20) begin
            bus_op(1'b0, 1'b1, 8'h00);
            polls++;
        end
        chk("clr_poll_timeout", {31'd0, lcd.LCD_DATA_OUT[7]}, 32'd0);
        chk("clr_busy_len", last_run, CC);
        chk("clr_err", err_seen - e0, 32'd0);
        chk("clr_ac", {25'd0, CURSOR_ADDR}, 32'd0);
        m_reset();
        check_mem("clr_peek");

        // Reset in the middle of the clear fill.
        bus_op(1'b0, 1'b0, 8'h0C); repeat (BC + 2) @(negedge CLK_1M);
        bus_op(1'b0, 1'b0, 8'h94); repeat (BC + 2) @(negedge CLK_1M);
        bus_op(1'b1, 1'b0, 8'h77); repeat (BC + 2) @(negedge CLK_1M);
        bus_op(1'b0, 1'b0, 8'h01);
        repeat (7) @(negedge CLK_1M);
        chk("midclr_busy", {31'd0, BUSY}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK_1M);
        chk("midclr_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("midclr_rst_ac",   {25'd0, CURSOR_ADDR}, 32'd0);
        chk("midclr_rst_disp", {31'd0, DISP_ON}, 32'd0);
        chk("midclr_rst_oe",   {31'd0, lcd.LCD_DATA_OE}, 32'd0);
        chk("midclr_rst_out",  {24'd0, lcd.LCD_DATA_OUT}, 32'd0);
        m_reset();
        check_mem("midclr_peek");
        RESET = 1'b0;
        repeat (2) @(negedge CLK_1M);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 15);
            rs = 1'b0; rw = 1'b0; d = 8'($urandom_range(0, 255));
            case (r)
                0, 1, 2, 3, 4: rs = 1'b1;
                5, 6:          begin rs = 1'b1; rw = 1'b1; end
                7:             rw = 1'b1;
                8:             d = ($urandom_range(0, 1) != 0) ? 8'(8'hC0 + $urandom_range(0, 15))
                                                               : 8'(8'h80 | $urandom_range(0, 127));
                9:             d = 8'(8'h40 + $urandom_range(0, 63));
                10:            d = 8'(8'h04 + $urandom_range(0, 3));
                11:            d = 8'(8'h08 + $urandom_range(0, 7));
                12:            d = 8'(8'h10 + $urandom_range(0, 15));
                13:            d = 8'(8'h20 + $urandom_range(0, 31));
                14:            d = 8'(8'h02 + $urandom_range(0, 1));
                default:       if ($urandom_range(0, 4) == 0) d = 8'h01; else rs = 1'b1;
            endcase
            e0 = err_seen;
            m_apply(rs, rw, d, exp_e, exp_o);
            bus_op(rs, rw, d);
            repeat (((!rs && !rw && d == 8'h01) ? CC : BC) + 2) @(negedge CLK_1M);
            chk($sformatf("rnd%0d_err", n),  err_seen - e0, {31'd0, exp_e});
            chk($sformatf("rnd%0d_ac", n),   {25'd0, CURSOR_ADDR}, {25'd0, m_ac()});
            chk($sformatf("rnd%0d_disp", n), {31'd0, DISP_ON}, {31'd0, m_d});
            if (rw) chk($sformatf("rnd%0d_out", n), {24'd0, lcd.LCD_DATA_OUT}, {24'd0, exp_o});
            if (n % 25 == 24) check_mem($sformatf("rnd%0d_peek", n));
        end
        check_mem("final_peek");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
